// File: rtl/countdown_timer_hex.sv
// Loadable down-counter with prescaler, optional auto-reload, expiry pulse
// and two active-low 7-segment digits showing the current count in hex.
module countdown_timer_hex #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 1,
  parameter int WRAP     = 0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             done,
  output logic [0:6]       HEX0,
  output logic [0:6]       HEX1
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload_reg, reload_next, q_next;
  logic [PW-1:0]    prescaler, prescaler_next;
  logic             done_next;

  always_ff @(posedge clk) begin
    if (!aclr) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      prescaler  <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      q          <= q_next;
      reload_reg <= reload_next;
      prescaler  <= prescaler_next;
      done       <= done_next;
    end
  end

  // Load always wins over counting; only RUN with enable advances the prescaler.
  always_comb begin
    state_next     = state;
    q_next         = q;
    reload_next    = reload_reg;
    prescaler_next = prescaler;
    done_next      = 1'b0;
    if (load) begin
      q_next         = load_value;
      reload_next    = load_value;
      prescaler_next = '0;
      state_next     = (load_value != '0) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (prescaler != TICK_LAST) begin
        prescaler_next = prescaler + 1'b1;
      end else begin
        prescaler_next = '0;
        if (q == WIDTH'(1)) begin
          q_next    = '0;
          done_next = 1'b1;
          if (WRAP == 0) state_next = EXPIRED;
        end else if (q == '0) begin
          if (WRAP != 0) q_next = reload_reg;
        end else begin
          q_next = q - 1'b1;
        end
      end
    end
  end

  function automatic logic [0:6] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  assign zero = (q == '0);
  assign HEX0 = seg_decode(q[3:0]);
  assign HEX1 = seg_decode(q[7:4]);

endmodule

// File: tb/tb_countdown_timer_hex.sv
// Scoreboard bench for countdown_timer_hex: three instances cover plain,
// prescaled (TICK_DIV=4) and auto-reload (WRAP=1) configurations.
module tb_countdown_timer_hex;

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic       done;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       aclr [3];
  logic       enable [3];
  logic       load [3];
  logic [7:0] load_value [3];
  logic [7:0] q_o [3];
  logic       zero_o [3];
  logic       done_o [3];
  logic [0:6] hex0_o [3];
  logic [0:6] hex1_o [3];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [0:6] seg_table [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 clk = ~clk;

  countdown_timer_hex #(.WIDTH(8), .TICK_DIV(1), .WRAP(0)) dut0 (
    .clk(clk), .aclr(aclr[0]), .enable(enable[0]), .load(load[0]),
    .load_value(load_value[0]), .q(q_o[0]), .zero(zero_o[0]),
    .done(done_o[0]), .HEX0(hex0_o[0]), .HEX1(hex1_o[0]));

  countdown_timer_hex #(.WIDTH(8), .TICK_DIV(4), .WRAP(0)) dut1 (
    .clk(clk), .aclr(aclr[1]), .enable(enable[1]), .load(load[1]),
    .load_value(load_value[1]), .q(q_o[1]), .zero(zero_o[1]),
    .done(done_o[1]), .HEX0(hex0_o[1]), .HEX1(hex1_o[1]));

  countdown_timer_hex #(.WIDTH(8), .TICK_DIV(1), .WRAP(1)) dut2 (
    .clk(clk), .aclr(aclr[2]), .enable(enable[2]), .load(load[2]),
    .load_value(load_value[2]), .q(q_o[2]), .zero(zero_o[2]),
    .done(done_o[2]), .HEX0(hex0_o[2]), .HEX1(hex1_o[2]));

  // Drive one DUT for one clock edge and queue what it must show afterwards.
  task automatic applyStimulus(input int d, input logic rst_n, input logic en,
                               input logic ld, input logic [7:0] lv,
                               input logic [7:0] eq, input logic ed,
                               input string name);
    exp_t e;
    @(negedge clk);
    #1;
    aclr[d]       = rst_n;
    enable[d]     = en;
    load[d]       = ld;
    load_value[d] = lv;
    e.dut  = d;
    e.q    = eq;
    e.done = ed;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [0:6] eh0, eh1;
    logic       ez;
    eh0 = seg_table[e.q[3:0]];
    eh1 = seg_table[e.q[7:4]];
    ez  = (e.q == 8'h00);
    checks++;
    if (q_o[e.dut] !== e.q || zero_o[e.dut] !== ez || done_o[e.dut] !== e.done ||
        hex0_o[e.dut] !== eh0 || hex1_o[e.dut] !== eh1) begin
      failures++;
      $display("[TB] FAIL %s dut%0d: got q=%h zero=%b done=%b hex1=%b hex0=%b, expected q=%h zero=%b done=%b hex1=%b hex0=%b",
               e.name, e.dut, q_o[e.dut], zero_o[e.dut], done_o[e.dut],
               hex1_o[e.dut], hex0_o[e.dut], e.q, ez, e.done, eh1, eh0);
    end
  endtask

  // Monitor: every falling edge, the oldest pending expectation is due.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      aclr[i] = 1'b0; enable[i] = 1'b0; load[i] = 1'b0; load_value[i] = 8'h00;
    end

    // Reset beats load and enable on every instance
    applyStimulus(0, 0, 1, 1, 8'h55, 8'h00, 0, "reset0");
    applyStimulus(1, 0, 1, 1, 8'h55, 8'h00, 0, "reset1");
    applyStimulus(2, 0, 1, 1, 8'h55, 8'h00, 0, "reset2");

    // Plain countdown 3,2,1,0 then hold at zero
    applyStimulus(0, 1, 0, 1, 8'h03, 8'h03, 0, "load3");
    applyStimulus(0, 1, 1, 0, 8'h00, 8'h02, 0, "cnt2");
    applyStimulus(0, 1, 1, 0, 8'h00, 8'h01, 0, "cnt1");
    applyStimulus(0, 1, 1, 0, 8'h00, 8'h00, 1, "expire");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 8'h00, 8'h00, 0, "hold0");

    // Loading zero stays idle; A5 shows A and 5
    applyStimulus(0, 1, 1, 1, 8'h00, 8'h00, 0, "load0");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'h00, 8'h00, 0, "idle0");
    applyStimulus(0, 1, 0, 1, 8'hA5, 8'hA5, 0, "loadA5");
    applyStimulus(0, 1, 0, 0, 8'h00, 8'hA5, 0, "freezeA5");

    // Reload mid-count, then reset aborts the count
    applyStimulus(0, 1, 1, 1, 8'h42, 8'h42, 0, "load42");
    applyStimulus(0, 1, 1, 0, 8'h00, 8'h41, 0, "cnt41");
    applyStimulus(0, 1, 1, 0, 8'h00, 8'h40, 0, "cnt40");
    applyStimulus(0, 1, 1, 1, 8'h10, 8'h10, 0, "reload10");
    for (int v = 15; v >= 5; v--) applyStimulus(0, 1, 1, 0, 8'h00, 8'(v), 0, "cntdown");
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00, 0, "abort");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'h00, 8'h00, 0, "postabort");

    // Prescaled: decrement on every 4th enabled cycle, phase frozen by enable=0
    applyStimulus(1, 1, 0, 1, 8'h02, 8'h02, 0, "pload2");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h02, 0, "ph1");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h02, 0, "ph2");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h02, 0, "ph3");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h01, 0, "ptick1");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h01, 0, "ph1b");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h01, 0, "ph2b");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 8'h00, 8'h01, 0, "pfreeze");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h01, 0, "ph3b");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h00, 1, "pexpire");
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 8'h00, 8'h00, 0, "phold");

    // Auto-reload: 2,1,0,2,1,0,2 with a done pulse at each zero
    applyStimulus(2, 1, 0, 1, 8'h02, 8'h02, 0, "wload2");
    applyStimulus(2, 1, 1, 0, 8'h00, 8'h01, 0, "w1a");
    applyStimulus(2, 1, 1, 0, 8'h00, 8'h00, 1, "w0a");
    applyStimulus(2, 1, 1, 0, 8'h00, 8'h02, 0, "w2a");
    applyStimulus(2, 1, 1, 0, 8'h00, 8'h01, 0, "w1b");
    applyStimulus(2, 1, 1, 0, 8'h00, 8'h00, 1, "w0b");
    applyStimulus(2, 1, 1, 0, 8'h00, 8'h02, 0, "w2b");

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
